muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 153 +++++++++++++++
 tb/tb_muldiv_unit.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// HI/LO multiply-divide unit: single-cycle 32x32 multiply and a 32-step
// restoring divider that share the HI/LO result registers.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        divzero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  count;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        is_signed;
    logic        sign_a;
    logic        sign_b;
    logic        zero_div;
    logic [31:0] rem;
    logic [31:0] quot;
    logic [31:0] divisor;

    logic        start_signed;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic [32:0] shifted;
    logic        fits;
    logic [31:0] diff;
    logic [31:0] rem_next;
    logic [31:0] quot_next;
    logic [31:0] q_res;
    logic [31:0] r_res;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (op[1] && (b != 32'd0)) ? DIV : MUL;
                end
            end
            MUL:     state_next = IDLE;
            DIV:     state_next = (count == 5'd31) ? IDLE : DIV;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Even opcodes (MULT, DIV) are the signed variants.
    assign start_signed = ~op[0];
    assign mag_a = (start_signed && a[31]) ? (32'd0 - a) : a;
    assign mag_b = (start_signed && b[31]) ? (32'd0 - b) : b;

    assign ext_a = is_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    assign ext_b = is_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    assign prod  = ext_a * ext_b;

    // One restoring step: the partial remainder pulls in the next dividend bit
    // from the top of the quotient register, which shifts quotient bits in below.
    assign shifted   = {rem, quot[31]};
    assign fits      = (shifted >= {1'b0, divisor});
    assign diff      = shifted[31:0] - divisor;
    assign rem_next  = fits ? diff : shifted[31:0];
    assign quot_next = {quot[30:0], fits};
    assign q_res     = (is_signed && (sign_a ^ sign_b)) ? (32'd0 - quot_next) : quot_next;
    assign r_res     = (is_signed && sign_a) ? (32'd0 - rem_next) : rem_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 5'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            is_signed <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            zero_div  <= 1'b0;
            rem       <= 32'd0;
            quot      <= 32'd0;
            divisor   <= 32'd0;
            hi        <= 32'd0;
            lo        <= 32'd0;
            done      <= 1'b0;
            divzero   <= 1'b0;
        end else begin
            state   <= state_next;
            done    <= 1'b0;
            divzero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q       <= a;
                        b_q       <= b;
                        is_signed <= start_signed;
                        sign_a    <= a[31];
                        sign_b    <= b[31];
                        zero_div  <= op[1] && (b == 32'd0);
                        rem       <= 32'd0;
                        quot      <= mag_a;
                        divisor   <= mag_b;
                        count     <= 5'd0;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                MUL: begin
                    done <= 1'b1;
                    if (zero_div) begin
                        hi      <= a_q;
                        lo      <= 32'hFFFF_FFFF;
                        divzero <= 1'b1;
                    end else begin
                        hi <= prod[63:32];
                        lo <= prod[31:0];
                    end
                end
                DIV: begin
                    rem   <= rem_next;
                    quot  <= quot_next;
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        hi   <= r_res;
                        lo   <= q_res;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: multiply, divide, divide-by-zero, HI/LO
// moves, busy blocking and asynchronous reset.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        divzero;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    muldiv_unit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .divzero (divzero),
        .hi      (hi),
        .lo      (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Called just after a negedge; drives start for one edge and returns the
    // number of negedges until done is seen (-1 if it never came).
    task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, output int cycles);
        start  = 1'b1;
        op     = o;
        a      = x;
        b      = y;
        cycles = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (done) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int cyc;
        #1 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || divzero !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b divzero=%b hi=%h lo=%h required all zero",
                     busy, done, divzero, hi, lo);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_op(OP_MULTU, 32'd4, 32'd5, cyc);
        checks++;
        if (cyc !== 2 || lo !== 32'd20 || hi !== 32'd0) begin
            errors++;
            $display("FAIL first_start: cycles=%0d hi=%h lo=%h required 2 0 00000014", cyc, hi, lo);
        end
    endtask

    task automatic test_multu();
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'hFFFF_FFFF;
        b     = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL multu_busy: busy=%b done=%b required 1 0", busy, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            errors++;
            $display("FAIL multu_result: done=%b busy=%b hi=%h lo=%h required 1 0 fffffffe 00000001",
                     done, busy, hi, lo);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL multu_done_pulse: done=%b required 0", done);
        end
    endtask

    task automatic test_mult_back_to_back();
        int cyc;
        run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, cyc);
        checks++;
        if (cyc !== 2 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
            errors++;
            $display("FAIL mult_signed: cycles=%0d hi=%h lo=%h required 2 ffffffff fffffffa", cyc, hi, lo);
        end
        run_op(OP_MULTU, 32'd7, 32'd6, cyc);
        checks++;
        if (cyc !== 2 || hi !== 32'd0 || lo !== 32'h0000_002A) begin
            errors++;
            $display("FAIL back_to_back: cycles=%0d hi=%h lo=%h required 2 0 0000002a", cyc, hi, lo);
        end
    endtask

    task automatic test_divide();
        int cyc;
        run_op(OP_DIVU, 32'd100, 32'd7, cyc);
        checks++;
        if (cyc !== 33 || lo !== 32'h0000_000E || hi !== 32'h0000_0002) begin
            errors++;
            $display("FAIL divu: cycles=%0d hi=%h lo=%h required 33 00000002 0000000e", cyc, hi, lo);
        end
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, cyc);
        checks++;
        if (cyc !== 33 || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF || divzero !== 1'b0) begin
            errors++;
            $display("FAIL div_signed: cycles=%0d hi=%h lo=%h divzero=%b required 33 ffffffff fffffffd 0",
                     cyc, hi, lo, divzero);
        end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        checks++;
        if (cyc !== 33 || lo !== 32'h8000_0000 || hi !== 32'd0 || divzero !== 1'b0) begin
            errors++;
            $display("FAIL div_overflow: cycles=%0d hi=%h lo=%h divzero=%b required 33 0 80000000 0",
                     cyc, hi, lo, divzero);
        end
    endtask

    task automatic test_divzero();
        int cyc;
        run_op(OP_DIV, 32'd5, 32'd0, cyc);
        checks++;
        if (cyc !== 2 || lo !== 32'hFFFF_FFFF || hi !== 32'd5 || divzero !== 1'b1) begin
            errors++;
            $display("FAIL divzero: cycles=%0d hi=%h lo=%h divzero=%b required 2 00000005 ffffffff 1",
                     cyc, hi, lo, divzero);
        end
        @(negedge clk);
        checks++;
        if (divzero !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL divzero_pulse: divzero=%b done=%b required 0 0", divzero, done);
        end
    endtask

    task automatic test_ignore_while_busy();
        int cyc;
        start = 1'b1;
        op    = OP_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        cyc   = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 3) begin
                mthi  = 1'b1;
                wdata = 32'h0000_1234;
                start = 1'b1;
                op    = OP_MULTU;
                a     = 32'd3;
                b     = 32'd3;
            end
            if (k == 5) begin
                mthi  = 1'b0;
                start = 1'b0;
            end
            if (k == 6) begin
                checks++;
                if (hi !== 32'd5 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_mthi_ignored: hi=%h busy=%b required 00000005 1", hi, busy);
                end
            end
            if (done) begin
                cyc = k;
                break;
            end
        end
        checks++;
        if (cyc !== 33 || lo !== 32'h0000_000E || hi !== 32'h0000_0002) begin
            errors++;
            $display("FAIL busy_start_ignored: cycles=%0d hi=%h lo=%h required 33 00000002 0000000e",
                     cyc, hi, lo);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_div: busy=%b required 0", busy);
        end
    endtask

    task automatic test_mthi_mtlo();
        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        checks++;
        if (hi !== 32'hA5A5_A5A5 || lo !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL mthi_mtlo_both: hi=%h lo=%h required a5a5a5a5 a5a5a5a5", hi, lo);
        end
        mtlo  = 1'b1;
        wdata = 32'h0000_0011;
        @(negedge clk);
        mtlo = 1'b0;
        checks++;
        if (hi !== 32'hA5A5_A5A5 || lo !== 32'h0000_0011) begin
            errors++;
            $display("FAIL mtlo_only: hi=%h lo=%h required a5a5a5a5 00000011", hi, lo);
        end
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'd2;
        b     = 32'd3;
        mtlo  = 1'b1;
        wdata = 32'h0000_DEAD;
        @(negedge clk);
        start = 1'b0;
        mtlo  = 1'b0;
        checks++;
        if (lo !== 32'h0000_0011 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_beats_mtlo: lo=%h busy=%b required 00000011 1", lo, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || lo !== 32'd6 || hi !== 32'd0) begin
            errors++;
            $display("FAIL start_mtlo_result: done=%b hi=%h lo=%h required 1 0 00000006", done, hi, lo);
        end
    endtask

    task automatic test_reset_mid_div();
        int seen_done;
        start = 1'b1;
        op    = OP_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_busy: busy=%b required 1", busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: hi=%h lo=%h busy=%b done=%b required 0 0 0 0", hi, lo, busy, done);
        end
        @(negedge clk);
        reset     = 1'b0;
        seen_done = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            errors++;
            $display("FAIL no_done_after_reset: active_cycles=%0d required 0", seen_done);
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = 32'd0;
        b     = 32'd0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        wdata = 32'd0;
        test_reset();
        test_multu();
        test_mult_back_to_back();
        test_divide();
        test_divzero();
        test_ignore_while_busy();
        test_mthi_mtlo();
        test_reset_mid_div();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
